pwm_multichannel_shadowed: RTL and testbench

//  N-channel, W-bit PWM generator. Successor to the 3-bit/8-channel driver.

---
 rtl/pwm_multichannel_shadowed_if.sv | 26 ++
 rtl/pwm_multichannel_shadowed.sv | 161 ++++++++++++++++
 tb/tb_pwm_multichannel_shadowed.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_shadowed_if.sv
// Host-side register bus of the shadowed PWM block.
// The host (master) writes duty values into per-channel shadow registers and
// requests a commit; the PWM block (slave) reports whether a commit is still
// waiting for the next period boundary.
//   wr_en       host -> pwm   write wr_data into shadow[wr_addr]
//   wr_addr     host -> pwm   channel index (indices >= CHANNELS are ignored)
//   wr_data     host -> pwm   duty value 0..2**WIDTH-1
//   commit      host -> pwm   pulse: request shadow -> active copy
//   commit_pend pwm -> host   commit requested but not yet applied
interface pwm_multichannel_shadowed_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8
);
  localparam int ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              commit;
  logic              commit_pend;

  modport master (output wr_en, output wr_addr, output wr_data, output commit,
                  input  commit_pend);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  commit,
                  output commit_pend);
endinterface

// File: rtl/pwm_multichannel_shadowed.sv
// N-channel, W-bit PWM generator with shadowed duty registers.
// Duty values are written into shadow registers and copied into the active set
// only at a PWM period boundary (or immediately while idle), so an output never
// changes duty mid-period. A prescaler slows the counter; the counter is either a
// sawtooth (edge aligned) or an up/down triangle (centre aligned).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        1 = run the counter, 0 = idle (outputs at polarity level)
//   prescale      counter advances every prescale+1 clocks
//   polarity      per-channel output inversion
//   bus (slave)   shadow write / commit interface, commit_pend status
//   period_start  1-clock pulse after each period boundary
//   pwm_out       registered PWM outputs
module pwm_multichannel_shadowed #(
  parameter int CHANNELS       = 8,
  parameter int WIDTH          = 8,
  parameter int PRESCALE_W     = 8,
  parameter bit CENTER_ALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CHANNELS-1:0]   polarity,
  pwm_multichannel_shadowed_if.slave bus,
  output logic                  period_start,
  output logic [CHANNELS-1:0]   pwm_out
);
  localparam int ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Last counter value of a ramp: MAX-1, so a period is MAX ticks per ramp.
  localparam logic [WIDTH-1:0]      CNT_LAST = WIDTH'((2 ** WIDTH) - 2);
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE  = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] psc_cnt_r;
  logic [WIDTH-1:0]      cnt_r;
  logic                  dir_down_r;
  logic [WIDTH-1:0]      shadow_r [CHANNELS];
  logic [WIDTH-1:0]      active_r [CHANNELS];
  logic                  commit_pend_r;
  logic                  period_start_r;
  logic [CHANNELS-1:0]   pwm_out_r;

  logic                  tick_s;
  logic                  boundary_s;
  logic                  apply_s;
  logic [PRESCALE_W-1:0] psc_nxt_s;
  logic [WIDTH-1:0]      cnt_nxt_s;
  logic                  dir_nxt_s;

  // Prescaler tick, counter next state and period boundary detection
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    psc_nxt_s  = '0;
    cnt_nxt_s  = '0;
    dir_nxt_s  = 1'b0;
    if (enable) begin
      // >= rather than == so that lowering prescale mid-count ticks at once
      tick_s    = (psc_cnt_r >= prescale);
      psc_nxt_s = tick_s ? '0 : (psc_cnt_r + PSC_ONE);
      cnt_nxt_s = cnt_r;
      dir_nxt_s = dir_down_r;
      if (!tick_s) begin
        cnt_nxt_s = cnt_r;
      end else if (CENTER_ALIGNED) begin
        // Triangle: each end value is held for one tick while direction flips
        if (!dir_down_r) begin
          if (cnt_r == CNT_LAST) begin
            dir_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          if (cnt_r == '0) begin
            dir_nxt_s  = 1'b0;
            boundary_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end
        end
      end else begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s  = '0;
          boundary_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
    end else begin
      tick_s = 1'b0;
    end
  end

  // While idle there is no period to wait for, so a commit lands on the next clock
  assign apply_s = (commit_pend_r | bus.commit) & (boundary_s | ~enable);

  // Prescaler, counter and direction state
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_cnt_r  <= '0;
      cnt_r      <= '0;
      dir_down_r <= 1'b0;
    end else begin
      psc_cnt_r  <= psc_nxt_s;
      cnt_r      <= cnt_nxt_s;
      dir_down_r <= dir_nxt_s;
    end
  end

  // Shadow registers; an out-of-range address matches no channel and is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
          shadow_r[i] <= bus.wr_data;
        end
      end
    end
  end

  // Active duty set and commit handshake; the copy takes this cycle's shadow values
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active_r[i] <= '0;
      end
      commit_pend_r <= 1'b0;
    end else begin
      if (apply_s) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active_r[i] <= shadow_r[i];
        end
        commit_pend_r <= 1'b0;
      end else if (bus.commit) begin
        commit_pend_r <= 1'b1;
      end
    end
  end

  // Registered compare outputs and period start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out_r      <= '0;
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= boundary_s;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out_r[i] <= enable ? ((cnt_r < active_r[i]) ^ polarity[i]) : polarity[i];
      end
    end
  end

  assign bus.commit_pend = commit_pend_r;
  assign period_start    = period_start_r;
  assign pwm_out         = pwm_out_r;
endmodule

// File: tb/tb_pwm_multichannel_shadowed.sv
// Self-checking bench for pwm_multichannel_shadowed (4 channels, 4-bit duty,
// MAX=15). One edge-aligned and one centre-aligned instance share clock, reset,
// enable, prescale and polarity. Each scenario computes the expected outputs
// for the coming edge from period arithmetic, queues them, and compares them
// against the DUT once that edge has happened.
`timescale 1ns/1ps
module tb_pwm_multichannel_shadowed;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int PW = 4;

  typedef struct {
    logic [CH-1:0] pwm;
    logic          pend;
    logic          ps;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [CH-1:0] polarity;
  logic          ps_e, ps_c;
  logic [CH-1:0] pwm_e, pwm_c;

  exp_t sb_q[$];
  exp_t ex;
  exp_t got;
  int   passed_cnt = 0;
  int   total_cnt  = 0;

  pwm_multichannel_shadowed_if #(.CHANNELS(CH), .WIDTH(W)) bus_e ();
  pwm_multichannel_shadowed_if #(.CHANNELS(CH), .WIDTH(W)) bus_c ();

  pwm_multichannel_shadowed #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW), .CENTER_ALIGNED(1'b0)) dut_e (
    .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .polarity(polarity),
    .bus(bus_e), .period_start(ps_e), .pwm_out(pwm_e)
  );

  pwm_multichannel_shadowed #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW), .CENTER_ALIGNED(1'b1)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .polarity(polarity),
    .bus(bus_c), .period_start(ps_c), .pwm_out(pwm_c)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_e.wr_en = 1'b0; bus_e.wr_addr = 2'd0; bus_e.wr_data = 4'd0; bus_e.commit = 1'b0;
    bus_c.wr_en = 1'b0; bus_c.wr_addr = 2'd0; bus_c.wr_data = 4'd0; bus_c.commit = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [3:0] data);
    bus_e.wr_en = 1'b1; bus_e.wr_addr = addr; bus_e.wr_data = data;
    bus_c.wr_en = 1'b1; bus_c.wr_addr = addr; bus_c.wr_data = data;
  endtask

  task automatic set_commit();
    bus_e.commit = 1'b1;
    bus_c.commit = 1'b1;
  endtask

  // Two reset edges; on return the bench sits in cycle 0 with reset released.
  task automatic do_reset();
    bus_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable   = 1'b1;
    polarity = 4'b0000;
    prescale = 4'd0;
    bus_idle();
    reset = 1'b1;
    step();
    total_cnt++; if (pwm_e !== 4'b0000) $display("FAIL reset_pwm_e got=%b exp=0000", pwm_e); else passed_cnt++;
    total_cnt++; if (bus_e.commit_pend !== 1'b0) $display("FAIL reset_pend_e got=%b exp=0", bus_e.commit_pend); else passed_cnt++;
    total_cnt++; if (ps_e !== 1'b0) $display("FAIL reset_ps_e got=%b exp=0", ps_e); else passed_cnt++;
    total_cnt++; if (pwm_c !== 4'b0000) $display("FAIL reset_pwm_c got=%b exp=0000", pwm_c); else passed_cnt++;
    total_cnt++; if (bus_c.commit_pend !== 1'b0) $display("FAIL reset_pend_c got=%b exp=0", bus_c.commit_pend); else passed_cnt++;
  endtask

  // ch1=5 and ch2=15 committed early; applied at the first boundary (cycle 14).
  task automatic test_edge_commit();
    enable = 1'b1; polarity = 4'b0000; prescale = 4'd0;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      bus_idle();
      if (c == 0) bus_write(2'd1, 4'd5);
      else if (c == 2) bus_write(2'd2, 4'd15);
      else if (c == 3) set_commit();
      ex.pwm  = {1'b0, (c >= 15), ((c >= 15) && ((c % 15) < 5)), 1'b0};
      ex.pend = (c >= 3) && (c <= 13);
      ex.ps   = ((c % 15) == 14);
      sb_q.push_back(ex);
      step();
      got = sb_q.pop_front();
      total_cnt++; if (pwm_e !== got.pwm) $display("FAIL edge_pwm c=%0d got=%b exp=%b", c, pwm_e, got.pwm); else passed_cnt++;
      total_cnt++; if (bus_e.commit_pend !== got.pend) $display("FAIL edge_pend c=%0d got=%b exp=%b", c, bus_e.commit_pend, got.pend); else passed_cnt++;
      total_cnt++; if (ps_e !== got.ps) $display("FAIL edge_ps c=%0d got=%b exp=%b", c, ps_e, got.ps); else passed_cnt++;
    end
  endtask

  // prescale=2: one tick every 3 clocks, period 45; prescale dropped to 0 at cycle 100.
  task automatic test_prescale();
    int cnt;
    int tick;
    enable = 1'b1; polarity = 4'b0000; prescale = 4'd2;
    do_reset();
    for (int c = 0; c < 120; c++) begin
      bus_idle();
      if (c == 0) bus_write(2'd3, 4'd3);
      else if (c == 1) set_commit();
      else if (c == 100) prescale = 4'd0;
      if (c < 100) begin
        cnt  = (c / 3) % 15;
        tick = ((c % 3) == 2);
      end else begin
        cnt  = (c <= 111) ? (c - 97) : ((c - 112) % 15);
        tick = 1;
      end
      ex.pwm  = {((c >= 45) && (cnt < 3)), 3'b000};
      ex.pend = (c >= 1) && (c <= 43);
      ex.ps   = (tick == 1) && (cnt == 14);
      sb_q.push_back(ex);
      step();
      got = sb_q.pop_front();
      total_cnt++; if (pwm_e !== got.pwm) $display("FAIL psc_pwm c=%0d got=%b exp=%b", c, pwm_e, got.pwm); else passed_cnt++;
      total_cnt++; if (bus_e.commit_pend !== got.pend) $display("FAIL psc_pend c=%0d got=%b exp=%b", c, bus_e.commit_pend, got.pend); else passed_cnt++;
      total_cnt++; if (ps_e !== got.ps) $display("FAIL psc_ps c=%0d got=%b exp=%b", c, ps_e, got.ps); else passed_cnt++;
    end
  endtask

  // ch1=4 then 9 before commit: only 9 lands. Later ch1=2 committed in the boundary
  // cycle itself, alongside a ch0 write that must not be copied.
  task automatic test_last_write_wins();
    int act;
    enable = 1'b1; polarity = 4'b0000; prescale = 4'd0;
    do_reset();
    for (int c = 0; c < 46; c++) begin
      bus_idle();
      if (c == 3) bus_write(2'd1, 4'd4);
      else if (c == 5) bus_write(2'd1, 4'd9);
      else if (c == 6) set_commit();
      else if (c == 20) bus_write(2'd1, 4'd2);
      else if (c == 29) begin
        bus_write(2'd0, 4'd7);
        set_commit();
      end
      act     = (c < 15) ? 0 : ((c < 30) ? 9 : 2);
      ex.pwm  = {2'b00, ((c % 15) < act), 1'b0};
      ex.pend = (c >= 6) && (c <= 13);
      ex.ps   = ((c % 15) == 14);
      sb_q.push_back(ex);
      step();
      got = sb_q.pop_front();
      total_cnt++; if (pwm_e !== got.pwm) $display("FAIL lww_pwm c=%0d got=%b exp=%b", c, pwm_e, got.pwm); else passed_cnt++;
      total_cnt++; if (bus_e.commit_pend !== got.pend) $display("FAIL lww_pend c=%0d got=%b exp=%b", c, bus_e.commit_pend, got.pend); else passed_cnt++;
      total_cnt++; if (ps_e !== got.ps) $display("FAIL lww_ps c=%0d got=%b exp=%b", c, ps_e, got.ps); else passed_cnt++;
    end
  endtask

  // Centre-aligned: period 30, ch0=5 high 5 clocks at each end of the period.
  task automatic test_center();
    int p;
    int cnt;
    int hi_cnt;
    hi_cnt = 0;
    enable = 1'b1; polarity = 4'b0000; prescale = 4'd0;
    do_reset();
    for (int c = 0; c < 75; c++) begin
      bus_idle();
      if (c == 0) bus_write(2'd0, 4'd5);
      else if (c == 1) set_commit();
      p       = c % 30;
      cnt     = (p < 15) ? p : (29 - p);
      ex.pwm  = {3'b000, ((c >= 30) && (cnt < 5))};
      ex.pend = (c >= 1) && (c <= 28);
      ex.ps   = (p == 29);
      sb_q.push_back(ex);
      step();
      got = sb_q.pop_front();
      if ((c >= 30) && (c < 60) && (pwm_c[0] === 1'b1)) hi_cnt++;
      total_cnt++; if (pwm_c !== got.pwm) $display("FAIL ctr_pwm c=%0d got=%b exp=%b", c, pwm_c, got.pwm); else passed_cnt++;
      total_cnt++; if (bus_c.commit_pend !== got.pend) $display("FAIL ctr_pend c=%0d got=%b exp=%b", c, bus_c.commit_pend, got.pend); else passed_cnt++;
      total_cnt++; if (ps_c !== got.ps) $display("FAIL ctr_ps c=%0d got=%b exp=%b", c, ps_c, got.ps); else passed_cnt++;
    end
    total_cnt++; if (hi_cnt != 10) $display("FAIL ctr_high_clocks got=%0d exp=10", hi_cnt); else passed_cnt++;
  endtask

  // Idle with ch0 inverted, immediate commit while idle, enable rise, then a
  // mid-period reset that drops a pending commit.
  task automatic test_idle_polarity();
    int cnt;
    enable = 1'b0; polarity = 4'b0001; prescale = 4'd0;
    do_reset();
    for (int c = 0; c < 41; c++) begin
      bus_idle();
      reset = (c == 24);
      if (c == 0) bus_write(2'd2, 4'd6);
      else if (c == 1) set_commit();
      else if (c == 4) enable = 1'b1;
      else if (c == 23) begin
        bus_write(2'd1, 4'd9);
        set_commit();
      end
      if (c < 4) begin
        ex.pwm = 4'b0001; ex.pend = 1'b0; ex.ps = 1'b0;
      end else if (c < 24) begin
        cnt     = (c - 4) % 15;
        ex.pwm  = {1'b0, (cnt < 6), 1'b0, 1'b1};
        ex.pend = (c == 23);
        ex.ps   = (cnt == 14);
      end else if (c == 24) begin
        ex.pwm = 4'b0000; ex.pend = 1'b0; ex.ps = 1'b0;
      end else begin
        cnt     = (c - 25) % 15;
        ex.pwm  = 4'b0001;
        ex.pend = 1'b0;
        ex.ps   = (cnt == 14);
      end
      sb_q.push_back(ex);
      step();
      got = sb_q.pop_front();
      total_cnt++; if (pwm_e !== got.pwm) $display("FAIL idle_pwm c=%0d got=%b exp=%b", c, pwm_e, got.pwm); else passed_cnt++;
      total_cnt++; if (bus_e.commit_pend !== got.pend) $display("FAIL idle_pend c=%0d got=%b exp=%b", c, bus_e.commit_pend, got.pend); else passed_cnt++;
      total_cnt++; if (ps_e !== got.ps) $display("FAIL idle_ps c=%0d got=%b exp=%b", c, ps_e, got.ps); else passed_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    prescale = 4'd0;
    polarity = 4'b0000;
    bus_idle();
    test_reset();
    test_edge_commit();
    test_prescale();
    test_last_write_wins();
    test_center();
    test_idle_polarity();
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end
endmodule
